// File: rtl/s444_phase_scheduler_if.sv
// Requester-side bundle for s444_phase_scheduler: level requests and hold in,
// grant / guard / phase-code / done out.
interface s444_phase_scheduler_if;
  logic       req_a;
  logic       req_b;
  logic       hold;
  logic       gnt_a;
  logic       gnt_b;
  logic       clr;
  logic [2:0] phase;
  logic       done;

  modport master (
    output req_a, req_b, hold,
    input  gnt_a, gnt_b, clr, phase, done
  );

  modport slave (
    input  req_a, req_b, hold,
    output gnt_a, gnt_b, clr, phase, done
  );
endinterface

// File: rtl/s444_phase_scheduler.sv
// Timed round-robin two-requester scheduler: prescaler-paced GRANT phases, each followed by a
// CLEAR guard phase. Optional grant extension is enabled by defining EXTEND_EN.
module s444_phase_scheduler #(
  parameter int unsigned PRESCALE    = 3,
  parameter int unsigned GREEN_TICKS = 4,
  parameter int unsigned CLEAR_TICKS = 2,
  parameter int unsigned MAX_EXT     = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  s444_phase_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGntA = 3'd1,
    StClrA = 3'd2,
    StGntB = 3'd3,
    StClrB = 3'd4
  } state_e;

  localparam logic [3:0] PsMax = 4'(PRESCALE);
  localparam logic [3:0] Green = 4'(GREEN_TICKS);
  localparam logic [3:0] Clear = 4'(CLEAR_TICKS);

  state_e     state_q, state_d;
  logic [3:0] ps_q, ps_d;
  logic [3:0] tmr_q, tmr_d;
  logic       last_b_q, last_b_d;
  logic       done_d;
  logic       gnt_a_q, gnt_b_q, clr_q, done_q;
  logic [2:0] phase_q;
  logic       tick, expire, own_req, other_req, ext_ok;

`ifdef EXTEND_EN
  localparam logic [3:0] MaxExt = 4'(MAX_EXT);
  logic [3:0] ext_q, ext_d;
  assign ext_ok = (ext_q < MaxExt);
`else
  logic unused_max_ext;
  assign unused_max_ext = ^MAX_EXT;
  assign ext_ok = 1'b0;
`endif

  assign tick   = (ps_q == PsMax) && !bus.hold;
  assign expire = tick && (tmr_q == 4'd1);

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state_q)
      StGntA, StClrA: begin
        own_req   = bus.req_a;
        other_req = bus.req_b;
      end
      StGntB, StClrB: begin
        own_req   = bus.req_b;
        other_req = bus.req_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    tmr_d    = tmr_q;
    last_b_d = last_b_q;
    done_d   = 1'b0;
`ifdef EXTEND_EN
    ext_d    = ext_q;
`endif
    if (!bus.hold) ps_d = (ps_q == PsMax) ? 4'd0 : ps_q + 4'd1;
    if (tick && (tmr_q != 4'd0)) tmr_d = tmr_q - 4'd1;

    case (state_q)
      StIdle: begin
        if (!bus.hold && (bus.req_a || bus.req_b)) begin
          // With both requesting, the side that was not served last goes first.
          state_d = (bus.req_a && (!bus.req_b || last_b_q)) ? StGntA : StGntB;
          ps_d    = 4'd0;
          tmr_d   = Green;
`ifdef EXTEND_EN
          ext_d   = 4'd0;
`endif
        end
      end
      StGntA, StGntB: begin
        // Leave on expiry, or early on any tick where the owner has released.
        if (tick && (!own_req || (tmr_q == 4'd1))) begin
          if (own_req && !other_req && ext_ok) begin
            tmr_d = Green;
            ps_d  = 4'd0;
`ifdef EXTEND_EN
            ext_d = ext_q + 4'd1;
`endif
          end else begin
            state_d  = (state_q == StGntA) ? StClrA : StClrB;
            ps_d     = 4'd0;
            tmr_d    = Clear;
            last_b_d = (state_q == StGntB);
          end
        end
      end
      StClrA, StClrB: begin
        if (expire) begin
          done_d = 1'b1;
          ps_d   = 4'd0;
          if (other_req || own_req) begin
            if (other_req) state_d = (state_q == StClrA) ? StGntB : StGntA;
            else           state_d = (state_q == StClrA) ? StGntA : StGntB;
            tmr_d = Green;
`ifdef EXTEND_EN
            ext_d = 4'd0;
`endif
          end else begin
            state_d = StIdle;
            tmr_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        ps_d    = 4'd0;
        tmr_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ps_q     <= 4'd0;
      tmr_q    <= 4'd0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      clr_q    <= 1'b0;
      phase_q  <= 3'd0;
      done_q   <= 1'b0;
`ifdef EXTEND_EN
      ext_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      tmr_q    <= tmr_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= (state_d == StGntA);
      gnt_b_q  <= (state_d == StGntB);
      clr_q    <= (state_d == StClrA) || (state_d == StClrB);
      phase_q  <= state_d;
      done_q   <= done_d;
`ifdef EXTEND_EN
      ext_q    <= ext_d;
`endif
    end
  end

  assign bus.gnt_a = gnt_a_q;
  assign bus.gnt_b = gnt_b_q;
  assign bus.clr   = clr_q;
  assign bus.phase = phase_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_s444_phase_scheduler.sv
// Directed bench for s444_phase_scheduler at default parameters (PRESCALE=3, GREEN=4, CLEAR=2).
module tb_s444_phase_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   excl_viol = 0;

  s444_phase_scheduler_if bus ();

  s444_phase_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if ((bus.gnt_a && bus.gnt_b) || (bus.clr && (bus.gnt_a || bus.gnt_b))) excl_viol++;

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.gnt_a;
      1:       return bus.gnt_b;
      default: return bus.clr;
    endcase
  endfunction

  // Counts consecutive negedge samples for which the selected output is high (bounded).
  task automatic measure(input int sel, output int n);
    n = 0;
    while (sig(sel) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.hold  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.clr, bus.done, bus.phase} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {bus.gnt_a, bus.gnt_b, bus.clr, bus.done, bus.phase});
    end
  endtask

  task automatic test_single_a();
    int n;
    do_reset();
    bus.req_a = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt_a !== 1'b1 || bus.phase !== 3'd1) begin
      errors++;
      $display("FAIL single_first_grant: got gnt_a=%b phase=%0d expected 1/1", bus.gnt_a, bus.phase);
    end
    measure(0, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL single_gnt_len: got %0d expected 16", n); end
    checks++;
    if (bus.phase !== 3'd2) begin
      errors++; $display("FAIL single_clr_phase: got %0d expected 2", bus.phase);
    end
    measure(2, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL single_clr_len: got %0d expected 8", n); end
    checks++;
    if (bus.done !== 1'b1 || bus.gnt_a !== 1'b1 || bus.phase !== 3'd1) begin
      errors++;
      $display("FAIL single_regrant: got done=%b gnt_a=%b phase=%0d expected 1/1/1",
               bus.done, bus.gnt_a, bus.phase);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got 1 expected 0"); end
  endtask

  task automatic test_dual();
    int n;
    do_reset();
    excl_viol = 0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.phase !== 3'd1) begin errors++; $display("FAIL dual_first_a: got %0d expected 1", bus.phase); end
    measure(0, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL dual_a_len: got %0d expected 16", n); end
    checks++;
    if (bus.phase !== 3'd2) begin errors++; $display("FAIL dual_clr_a: got %0d expected 2", bus.phase); end
    measure(2, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL dual_clr_a_len: got %0d expected 8", n); end
    checks++;
    if (bus.phase !== 3'd3 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL dual_to_b: got phase=%0d done=%b expected 3/1", bus.phase, bus.done);
    end
    measure(1, n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL dual_b_len: got %0d expected 16", n); end
    checks++;
    if (bus.phase !== 3'd4) begin errors++; $display("FAIL dual_clr_b: got %0d expected 4", bus.phase); end
    measure(2, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL dual_clr_b_len: got %0d expected 8", n); end
    checks++;
    if (bus.phase !== 3'd1) begin errors++; $display("FAIL dual_back_to_a: got %0d expected 1", bus.phase); end
    checks++;
    if (excl_viol != 0) begin
      errors++; $display("FAIL mutual_exclusion: got %0d violations expected 0", excl_viol);
    end
  endtask

  task automatic test_hold();
    int  n;
    bit  bad_phase;
    do_reset();
    bus.req_b = 1'b1;
    @(negedge clk);
    n = 0;
    bad_phase = 1'b0;
    while (bus.gnt_b && n < 200) begin
      n++;
      if (bus.phase !== 3'd3) bad_phase = 1'b1;
      if (n == 5)  bus.hold = 1'b1;
      if (n == 15) bus.hold = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != 26) begin errors++; $display("FAIL hold_gnt_len: got %0d expected 26", n); end
    checks++;
    if (bad_phase) begin errors++; $display("FAIL hold_phase: got non-3 expected 3"); end
    checks++;
    if (bus.phase !== 3'd4) begin errors++; $display("FAIL hold_to_clr_b: got %0d expected 4", bus.phase); end
  endtask

  task automatic test_early_release();
    int n;
    do_reset();
    bus.req_a = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.gnt_a && n < 200) begin
      n++;
      if (n == 5) bus.req_a = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL early_gnt_len: got %0d expected 8", n); end
    measure(2, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL early_clr_len: got %0d expected 8", n); end
    checks++;
    if (bus.phase !== 3'd0 || bus.done !== 1'b1 || bus.gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL early_to_idle: got phase=%0d done=%b gnt_a=%b expected 0/1/0",
               bus.phase, bus.done, bus.gnt_a);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    bus.req_a = 1'b1;
    @(negedge clk);
    measure(0, n);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.phase !== 3'd2) begin errors++; $display("FAIL areset_in_clr: got %0d expected 2", bus.phase); end
    bus.req_a = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.clr, bus.done, bus.phase} !== 7'd0) begin
      errors++;
      $display("FAIL areset_async: got %b expected 0000000",
               {bus.gnt_a, bus.gnt_b, bus.clr, bus.done, bus.phase});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt_b !== 1'b1 || bus.phase !== 3'd3) begin
      errors++;
      $display("FAIL areset_regrant_b: got gnt_b=%b phase=%0d expected 1/3", bus.gnt_b, bus.phase);
    end
  endtask

`ifdef EXTEND_EN
  task automatic test_extend();
    int n;
    do_reset();
    bus.req_a = 1'b1;
    @(negedge clk);
    measure(0, n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL extend_gnt_len: got %0d expected 32", n); end
    measure(2, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL extend_clr_len: got %0d expected 8", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_dual();
    test_hold();
    test_early_release();
    test_async_reset();
`ifdef EXTEND_EN
    test_extend();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
